// File: rtl/rf_pkg.sv
// Shared defaults and scoreboard types for the register file.
package rf_pkg;

  localparam int unsigned DATA_WIDTH   = 16;
  localparam int unsigned REG_WIDTH    = 4;
  localparam int unsigned NUM_REGS     = 2 ** REG_WIDTH;
  localparam int unsigned SB_CNT_WIDTH = 2;
  localparam int unsigned SB_CNT_MAX   = (2 ** SB_CNT_WIDTH) - 1;

  typedef logic [SB_CNT_WIDTH-1:0] sb_cnt_t;

endpackage

// File: rtl/reg_file_if.sv
// Write-back, read-port and issue/scoreboard signals of the register file.
interface reg_file_if #(
  parameter int unsigned DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int unsigned REG_WIDTH  = rf_pkg::REG_WIDTH
);

  localparam int unsigned NUM_REGS = 2 ** REG_WIDTH;

  logic                  RegWriteW_i;
  logic [REG_WIDTH-1:0]  WriteRegW_i;
  logic [DATA_WIDTH-1:0] ResultW_i;
  logic [REG_WIDTH-1:0]  rs_addr_i;
  logic [REG_WIDTH-1:0]  rt_addr_i;
  logic [DATA_WIDTH-1:0] rs_data_o;
  logic [DATA_WIDTH-1:0] rt_data_o;
  logic                  issue_valid_i;
  logic                  issue_regwrite_i;
  logic [REG_WIDTH-1:0]  issue_dest_i;
  logic                  flush_i;
  logic                  stall_o;
  logic [NUM_REGS-1:0]   pending_o;
  logic                  sb_err_o;

  modport master (
    output RegWriteW_i, WriteRegW_i, ResultW_i, rs_addr_i, rt_addr_i,
    output issue_valid_i, issue_regwrite_i, issue_dest_i, flush_i,
    input  rs_data_o, rt_data_o, stall_o, pending_o, sb_err_o
  );

  modport slave (
    input  RegWriteW_i, WriteRegW_i, ResultW_i, rs_addr_i, rt_addr_i,
    input  issue_valid_i, issue_regwrite_i, issue_dest_i, flush_i,
    output rs_data_o, rt_data_o, stall_o, pending_o, sb_err_o
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register in-flight writer counters, issue stall and sticky error flag.
// Optional RF_BYPASS_EN: a last outstanding write-back clears its hazard in the same cycle.
module rf_scoreboard #(
  parameter int unsigned REG_WIDTH = rf_pkg::REG_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid_i,
  input  logic                        issue_regwrite_i,
  input  logic [REG_WIDTH-1:0]        issue_dest_i,
  input  logic [REG_WIDTH-1:0]        rs_addr_i,
  input  logic [REG_WIDTH-1:0]        rt_addr_i,
  input  logic                        wb_we_i,
  input  logic [REG_WIDTH-1:0]        wb_addr_i,
  input  logic                        flush_i,
  output logic                        stall_o,
  output logic [(2**REG_WIDTH)-1:0]   pending_o,
  output logic                        sb_err_o
);

  import rf_pkg::*;

  localparam int unsigned NUM_REGS = 2 ** REG_WIDTH;

  sb_cnt_t             cnt_q [NUM_REGS];
  sb_cnt_t             cnt_d [NUM_REGS];
  logic                err_q;
  logic                err_d;
  logic                rel_c;
  logic                res_c;
  logic [NUM_REGS-1:0] rel_vec_c;
  logic [NUM_REGS-1:0] res_vec_c;
  logic [NUM_REGS-1:0] eff_pend_c;

  assign rel_c     = wb_we_i & (wb_addr_i != '0);
  assign res_c     = issue_valid_i & issue_regwrite_i & ~stall_o & (issue_dest_i != '0);
  assign rel_vec_c = rel_c ? (NUM_REGS'(1) << wb_addr_i) : '0;
  assign res_vec_c = res_c ? (NUM_REGS'(1) << issue_dest_i) : '0;

  // Hazard view seen by issue this cycle; register 0 is never a hazard.
  always_comb begin : eff_pending
    for (int r = 0; r < NUM_REGS; r++) begin
      eff_pend_c[r] = (cnt_q[r] != '0);
    end
`ifdef RF_BYPASS_EN
    if (rel_c && (cnt_q[wb_addr_i] == sb_cnt_t'(1))) begin
      eff_pend_c[wb_addr_i] = 1'b0;
    end
`endif
    eff_pend_c[0] = 1'b0;
  end

  assign stall_o = issue_valid_i & (eff_pend_c[rs_addr_i] | eff_pend_c[rt_addr_i]);

  // Saturating counter update; flush wins over reserve/release.
  always_comb begin : cnt_next
    err_d = err_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush_i) begin
        cnt_d[r] = '0;
      end else if (res_vec_c[r] && !rel_vec_c[r]) begin
        if (cnt_q[r] == sb_cnt_t'(SB_CNT_MAX)) err_d = 1'b1;
        else                                   cnt_d[r] = cnt_q[r] + sb_cnt_t'(1);
      end else if (rel_vec_c[r] && !res_vec_c[r]) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - sb_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : cnt_reg
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin : pending_decode
    for (int r = 0; r < NUM_REGS; r++) pending_o[r] = (cnt_q[r] != '0);
  end

  assign sb_err_o = err_q;

endmodule

// File: rtl/reg_file.sv
// Register file with combinational read ports and a write-back scoreboard.
// Optional RF_BYPASS_EN: reads matching the active write-back return ResultW_i.
module reg_file #(
  parameter int unsigned DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int unsigned REG_WIDTH  = rf_pkg::REG_WIDTH
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  import rf_pkg::*;

  localparam int unsigned NUM_REGS = 2 ** REG_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rs_data_c;
  logic [DATA_WIDTH-1:0] rt_data_c;
  logic                  wb_we_c;

  assign wb_we_c = bus.RegWriteW_i & (bus.WriteRegW_i != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin : storage
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (wb_we_c) begin
      regs_q[bus.WriteRegW_i] <= bus.ResultW_i;
    end
  end

  always_comb begin : read_mux
    rs_data_c = regs_q[bus.rs_addr_i];
    rt_data_c = regs_q[bus.rt_addr_i];
`ifdef RF_BYPASS_EN
    if (wb_we_c && (bus.rs_addr_i == bus.WriteRegW_i)) rs_data_c = bus.ResultW_i;
    if (wb_we_c && (bus.rt_addr_i == bus.WriteRegW_i)) rt_data_c = bus.ResultW_i;
`endif
  end

  assign bus.rs_data_o = rs_data_c;
  assign bus.rt_data_o = rt_data_c;

  rf_scoreboard #(
    .REG_WIDTH (REG_WIDTH)
  ) u_scoreboard (
    .clk              (clk),
    .rst_n            (rst),
    .issue_valid_i    (bus.issue_valid_i),
    .issue_regwrite_i (bus.issue_regwrite_i),
    .issue_dest_i     (bus.issue_dest_i),
    .rs_addr_i        (bus.rs_addr_i),
    .rt_addr_i        (bus.rt_addr_i),
    .wb_we_i          (bus.RegWriteW_i),
    .wb_addr_i        (bus.WriteRegW_i),
    .flush_i          (bus.flush_i),
    .stall_o          (bus.stall_o),
    .pending_o        (bus.pending_o),
    .sb_err_o         (bus.sb_err_o)
  );

endmodule
